// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Brief    : Segment patterns, digit-select encodings, FSM state type and BCD
//            pair conversion shared by the scanned 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam logic [6:0] c_SEG_0 = 7'h3F;
    localparam logic [6:0] c_SEG_1 = 7'h06;
    localparam logic [6:0] c_SEG_2 = 7'h5B;
    localparam logic [6:0] c_SEG_3 = 7'h4F;
    localparam logic [6:0] c_SEG_4 = 7'h66;
    localparam logic [6:0] c_SEG_5 = 7'h6D;
    localparam logic [6:0] c_SEG_6 = 7'h7D;
    localparam logic [6:0] c_SEG_7 = 7'h07;
    localparam logic [6:0] c_SEG_8 = 7'h7F;
    localparam logic [6:0] c_SEG_9 = 7'h6F;

    localparam logic [1:0] c_EN_ONES = 2'b01;
    localparam logic [1:0] c_EN_TENS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HAVE_ONES = 2'd1,
        ST_HAVE_TENS = 2'd2
    } state_e;

    // tens*10 + ones built from shifts; 99 fits in 7 bits so no wrap.
    function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] t, input logic [3:0] o);
        logic [6:0] t7;
        t7 = {3'b000, t};
        return (t7 << 3) + (t7 << 1) + {3'b000, o};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_to_bcd.sv
// ============================================================================
// Module   : seg7_to_bcd
// Brief    : Combinational 7-segment (a=bit0 .. g=bit6) to BCD decode with a
//            legal-digit flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       legal_o
);

    always_comb begin
        bcd_o   = 4'd0;
        legal_o = 1'b1;
        case (seg_i)
            c_SEG_0: bcd_o = 4'd0;
            c_SEG_1: bcd_o = 4'd1;
            c_SEG_2: bcd_o = 4'd2;
            c_SEG_3: bcd_o = 4'd3;
            c_SEG_4: bcd_o = 4'd4;
            c_SEG_5: bcd_o = 4'd5;
            c_SEG_6: bcd_o = 4'd6;
            c_SEG_7: bcd_o = 4'd7;
            c_SEG_8: bcd_o = 4'd8;
            c_SEG_9: bcd_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Decodes a two-digit multiplexed 7-segment scan into BCD digits
//            and a binary value, with debounce, stale timeout and error pulse.
//            Optional saturating error counter enabled by SEG_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] discode,
    input  logic [1:0] enable,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       value_upd,
    output logic       code_err
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCW-1:0] c_STABLE  = SCW'(STABLE_CYC);
    localparam logic [TCW-1:0] c_TIMEOUT = TCW'(TIMEOUT_CYC);

    logic [8:0]     sync1_q, sync2_q, prev_q;
    logic [SCW-1:0] stab_q, stab_d;
    logic [TCW-1:0] to_q, to_d;
    state_e         state_q, state_d;
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     ones_q, ones_d, tens_q, tens_d;
    logic [6:0]     value_q, value_d;
    logic           valid_q, valid_d, upd_q, upd_d, err_q, err_d;

    logic           w_changed, w_hit, w_pos_ok, w_is_ones, w_accept, w_bad, w_timeout, w_legal;
    logic [3:0]     w_bcd;
    logic [1:0]     w_en;

    assign w_en = sync2_q[8:7];

    seg7_to_bcd u_dec (
        .seg_i   (sync2_q[6:0]),
        .bcd_o   (w_bcd),
        .legal_o (w_legal)
    );

    // Acceptance fires only on the cycle the counter first lands on STABLE_CYC.
    always_comb begin
        w_changed = (sync2_q != prev_q);
        if (w_changed)
            stab_d = SCW'(1);
        else if (stab_q == c_STABLE)
            stab_d = stab_q;
        else
            stab_d = stab_q + SCW'(1);
        w_hit     = (stab_d == c_STABLE) && (w_changed || (stab_q != c_STABLE));
        w_is_ones = (w_en == c_EN_ONES);
        w_pos_ok  = w_is_ones || (w_en == c_EN_TENS);
        w_accept  = w_hit && w_pos_ok && w_legal;
        w_bad     = w_hit && w_pos_ok && !w_legal;
        w_timeout = (to_q == c_TIMEOUT);
        if (w_accept)
            to_d = '0;
        else if (w_timeout)
            to_d = to_q;
        else
            to_d = to_q + TCW'(1);
    end

    always_comb begin
        logic       pub;
        logic [3:0] pub_t, pub_o;
        state_d = state_q;
        cand_d  = cand_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        value_d = value_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        err_d   = w_bad;
        pub     = 1'b0;
        pub_t   = tens_q;
        pub_o   = ones_q;

        if (w_accept) begin
            case (state_q)
                ST_IDLE: begin
                    cand_d  = w_bcd;
                    state_d = w_is_ones ? ST_HAVE_ONES : ST_HAVE_TENS;
                end
                ST_HAVE_ONES: begin
                    if (w_is_ones) begin
                        cand_d = w_bcd;
                    end else begin
                        pub   = 1'b1;
                        pub_t = w_bcd;
                        pub_o = cand_q;
                    end
                end
                ST_HAVE_TENS: begin
                    if (!w_is_ones) begin
                        cand_d = w_bcd;
                    end else begin
                        pub   = 1'b1;
                        pub_t = cand_q;
                        pub_o = w_bcd;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (w_bad || w_timeout) begin
            state_d = ST_IDLE;
            if (w_timeout)
                valid_d = 1'b0;
        end

        if (pub) begin
            state_d = ST_IDLE;
            ones_d  = pub_o;
            tens_d  = pub_t;
            value_d = bcd_pair_to_bin(pub_t, pub_o);
            valid_d = 1'b1;
            upd_d   = !valid_q || ({pub_t, pub_o} != {tens_q, ones_q});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            stab_q  <= '0;
            to_q    <= '0;
            state_q <= ST_IDLE;
            cand_q  <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {enable, discode};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            to_q    <= to_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            value_q <= value_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt_q <= '0;
        else if (err_q && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign ones        = ones_q;
    assign tens        = tens_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign value_upd   = upd_q;
    assign code_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// Module   : tb_seg_scan_decoder
// Brief    : Scoreboard bench: expected publish/error events are queued as the
//            scan is driven and matched against value_upd/code_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 4096;

    logic       clk;
    logic       rst;
    logic [6:0] discode;
    logic [1:0] enable;
    logic [3:0] ones, tens;
    logic [6:0] value;
    logic       value_valid, value_upd, code_err;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    seg_scan_decoder #(
        .STABLE_CYC  (STABLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .discode     (discode),
        .enable      (enable),
        .ones        (ones),
        .tens        (tens),
        .value       (value),
        .value_valid (value_valid),
        .value_upd   (value_upd),
        .code_err    (code_err)
`ifdef SEG_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int t;
        int o;
        int v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [6:0] segs [10];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [1:0] en, input logic [6:0] seg, input int n);
        enable  = en;
        discode = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_upd(input int t, input int o);
        exp_t e;
        e.is_err = 1'b0;
        e.t = t;
        e.o = o;
        e.v = t * 10 + o;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.t = 0;
        e.o = 0;
        e.v = 0;
        sb.push_back(e);
    endtask

    task automatic digit(input logic [1:0] en, input int d);
        hold(en, segs[d], 6);
    endtask

    task automatic idle(input int n);
        hold(2'b00, 7'h00, n);
    endtask

    // Pulse monitor: every value_upd/code_err pulse must match the queue head.
    always @(negedge clk) begin
        if (rst && (value_upd || code_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, value_upd, code_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_err) begin
                    chk("err_pulse", code_err, 1);
                    chk("err_no_upd", value_upd, 0);
                end else begin
                    chk("upd_pulse", value_upd, 1);
                    chk("upd_value", value, mon_e.v);
                    chk("upd_ones", ones, mon_e.o);
                    chk("upd_tens", tens, mon_e.t);
                    chk("upd_valid", value_valid, 1);
                end
            end
        end
    end

    initial begin
        segs[0] = 7'h3F; segs[1] = 7'h06; segs[2] = 7'h5B; segs[3] = 7'h4F; segs[4] = 7'h66;
        segs[5] = 7'h6D; segs[6] = 7'h7D; segs[7] = 7'h07; segs[8] = 7'h7F; segs[9] = 7'h6F;
        rst     = 1'b0;
        enable  = 2'b00;
        discode = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_ones", ones, 0);
        chk("rst_tens", tens, 0);
        chk("rst_value", value, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_upd", value_upd, 0);
        chk("rst_err", code_err, 0);
        rst = 1'b1;
        idle(8);

        // First frame 35, ones digit first.
        push_upd(3, 5);
        digit(2'b01, 5);
        digit(2'b10, 3);
        idle(6);
        chk("f35_value", value, 35);
        chk("f35_ones", ones, 5);
        chk("f35_tens", tens, 3);
        chk("f35_valid", value_valid, 1);

        // Identical frame: no update pulse expected.
        digit(2'b01, 5);
        digit(2'b10, 3);
        idle(6);
        chk("rep35_valid", value_valid, 1);
        chk("rep35_value", value, 35);

        // Three-cycle glitch must not be accepted; tens-first frame 72 follows.
        hold(2'b01, 7'h06, STABLE_CYC - 1);
        idle(6);
        push_upd(7, 2);
        digit(2'b10, 7);
        digit(2'b01, 2);
        idle(6);
        chk("f72_value", value, 72);

        // Illegal pattern drops the held ones candidate.
        digit(2'b01, 4);
        push_err();
        hold(2'b01, 7'h49, 6);
        idle(6);
`ifdef SEG_ERR_CNT_EN
        chk("err_cnt", err_cnt, 1);
`endif
        push_upd(9, 1);
        digit(2'b10, 9);
        digit(2'b01, 1);
        idle(6);
        chk("f91_value", value, 91);

        // Same-position replacement, then publish 42.
        push_upd(4, 2);
        digit(2'b01, 3);
        digit(2'b01, 2);
        digit(2'b10, 4);
        idle(6);
        chk("f42_value", value, 42);

        // Stale timeout.
        idle(TIMEOUT_CYC - 20);
        chk("pre_to_valid", value_valid, 1);
        idle(40);
        chk("to_valid", value_valid, 0);
        chk("to_value", value, 42);
        chk("to_ones", ones, 2);
        chk("to_tens", tens, 4);

        // Same content after timeout still pulses since valid was low.
        push_upd(4, 2);
        digit(2'b01, 2);
        digit(2'b10, 4);
        idle(6);
        chk("re42_valid", value_valid, 1);

        // Reset mid-frame discards the held ones candidate.
        digit(2'b01, 7);
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("rst2_valid", value_valid, 0);
        rst = 1'b1;
        idle(4);
        digit(2'b10, 1);
        idle(10);
        chk("post_rst_value", value, 0);
        chk("post_rst_valid", value_valid, 0);
        chk("post_rst_tens", tens, 0);

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
